// File: rtl/level_pkg.sv
// Shared definitions for the bar-level display sequencer: level width,
// saturation limit and FSM state encodings.
package level_pkg;

  localparam int LEVEL_W = 3;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 3'd7;
  localparam logic [LEVEL_W-1:0] LEVEL_MIN = 3'd0;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

endpackage

// File: rtl/level_sequencer_blink_prescaler.sv
// Blink phase generator: toggles blink every BLINK_DIV cycles while run=1;
// run=0 or restart forces counter and phase back to zero.
module blink_prescaler #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic restart,
  output logic blink
);

  localparam int PW = $clog2(BLINK_DIV);
  localparam logic [PW-1:0] TC = PW'(BLINK_DIV - 1);

  logic [PW-1:0] cnt_r;
  logic          blink_r;

  // Prescaler counter and blink phase register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r   <= '0;
      blink_r <= 1'b0;
    end else if (restart || !run) begin
      cnt_r   <= '0;
      blink_r <= 1'b0;
    end else if (cnt_r == TC) begin
      cnt_r   <= '0;
      blink_r <= ~blink_r;
    end else begin
      cnt_r   <= cnt_r + PW'(1);
      blink_r <= blink_r;
    end
  end

  assign blink = blink_r;

endmodule

// File: rtl/level_sequencer.sv
// Bar-level display sequencer: fill level 0..7, EMPTY/PARTIAL/FULL FSM and
// blink phase for the row decoder. Define LEVEL_WRAP_EN to wrap 7<->0.
module level_sequencer
  import level_pkg::*;
#(
  parameter int BLINK_DIV = 25000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               dec,
  input  logic               clear,
  output logic [LEVEL_W-1:0] count,
  output logic               blink,
  output logic               full,
  output logic               empty
);

`ifdef LEVEL_WRAP_EN
  localparam logic WRAP_EN = 1'b1;
`else
  localparam logic WRAP_EN = 1'b0;
`endif

  state_t             state_r, state_nxt_s;
  logic [LEVEL_W-1:0] count_r, count_nxt_s;
  logic               inc_q_r, dec_q_r;
  logic               full_r, empty_r;
  logic               full_nxt_s, empty_nxt_s;
  logic               inc_rise_s, dec_rise_s;
  logic               inc_op_s, dec_op_s;
  logic               changed_s;

  assign inc_rise_s = inc & ~inc_q_r;
  assign dec_rise_s = dec & ~dec_q_r;
  // Simultaneous rises cancel; clear overrides both
  assign inc_op_s   = ~clear & inc_rise_s & ~dec_rise_s;
  assign dec_op_s   = ~clear & dec_rise_s & ~inc_rise_s;

  // Edge history; resets high so a button held through reset does not fire
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inc_q_r <= 1'b1;
      dec_q_r <= 1'b1;
    end else begin
      inc_q_r <= inc;
      dec_q_r <= dec;
    end
  end

  // Next fill level with saturation or wrap at the ends
  always_comb begin
    count_nxt_s = count_r;
    if (clear) begin
      count_nxt_s = LEVEL_MIN;
    end else if (inc_op_s) begin
      if ((count_r != LEVEL_MAX) || WRAP_EN) begin
        count_nxt_s = count_r + 3'd1;
      end else begin
        count_nxt_s = count_r;
      end
    end else if (dec_op_s) begin
      if ((count_r != LEVEL_MIN) || WRAP_EN) begin
        count_nxt_s = count_r - 3'd1;
      end else begin
        count_nxt_s = count_r;
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  assign changed_s = (count_nxt_s != count_r);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (clear) begin
          state_nxt_s = ST_EMPTY;
        end else if (inc_op_s) begin
          state_nxt_s = ST_PARTIAL;
        end else if (dec_op_s && WRAP_EN) begin
          state_nxt_s = ST_FULL;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_PARTIAL: begin
        if (clear) begin
          state_nxt_s = ST_EMPTY;
        end else if (inc_op_s && (count_r == LEVEL_MAX - 3'd1)) begin
          state_nxt_s = ST_FULL;
        end else if (dec_op_s && (count_r == LEVEL_MIN + 3'd1)) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_PARTIAL;
        end
      end
      ST_FULL: begin
        if (clear) begin
          state_nxt_s = ST_EMPTY;
        end else if (dec_op_s) begin
          state_nxt_s = ST_PARTIAL;
        end else if (inc_op_s && WRAP_EN) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
      end
    endcase
  end

  // FSM output decode from the next state so flags align with count
  always_comb begin
    full_nxt_s  = 1'b0;
    empty_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_EMPTY:   empty_nxt_s = 1'b1;
      ST_FULL:    full_nxt_s  = 1'b1;
      ST_PARTIAL: begin
        full_nxt_s  = 1'b0;
        empty_nxt_s = 1'b0;
      end
      default: begin
        full_nxt_s  = 1'b0;
        empty_nxt_s = 1'b1;
      end
    endcase
  end

  // Level and flag output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= LEVEL_MIN;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      count_r <= count_nxt_s;
      full_r  <= full_nxt_s;
      empty_r <= empty_nxt_s;
    end
  end

  // Any level change restarts the phase so the new level shows steady first
  blink_prescaler #(
    .BLINK_DIV (BLINK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .run     (state_r != ST_FULL),
    .restart (changed_s),
    .blink   (blink)
  );

  assign count = count_r;
  assign full  = full_r;
  assign empty = empty_r;

endmodule

// File: doc/level_sequencer.md
Name: level_sequencer

Overview:
- Sequences the 7-row bar-level display.
- Owns the 0..7 fill level and the blink phase.
- Drives the `count[2:0]` and `blink` inputs of the row decoder, which lights `count` rows plus one flashing "next" row while `blink`=1.
- Inputs come from synchronized, debounced pushbuttons: increment, decrement and clear.

Parameters:
- BLINK_DIV, 25000000: clock cycles per blink half-period (0.5 s at 50 MHz); legal range >= 2.
- PW, $clog2(BLINK_DIV): prescaler width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- inc  in  1  increment request, level, synchronous to clk; acts on rising edge.
- dec  in  1  decrement request, level, synchronous to clk; acts on rising edge.
- clear  in  1  synchronous clear, level-sensitive, highest priority.
- count  out  3  fill level to the row decoder, registered.
- blink  out  1  blink phase to the row decoder, registered.
- full  out  1  high when count==7, registered.
- empty  out  1  high when count==0, registered.

Behaviour:
- Reset (async assert, sync release):
  - count=0, blink=0, full=0, empty=1.
  - state=EMPTY, prescaler=0.
  - Edge-history regs inc_q=dec_q=1, so a button held through reset does not fire.
- Edge detect:
  - inc_rise = inc & ~inc_q; dec_rise = dec & ~dec_q.
  - inc_q/dec_q sample inc/dec every cycle.
- Latency: count changes on the same clk edge that samples the rise, i.e. 1 cycle after the input goes high.
- Per-edge priority:
  - clear=1: count<=0, state<=EMPTY, regardless of inc/dec.
  - else inc_rise & dec_rise: no change.
  - else inc_rise: count+1, saturating at 7 unless LEVEL_WRAP_EN.
  - else dec_rise: count-1, saturating at 0 unless LEVEL_WRAP_EN.
- FSM states EMPTY (count==0), PARTIAL (1..6), FULL (count==7):
  - EMPTY -inc-> PARTIAL.
  - PARTIAL -inc at 6-> FULL.
  - PARTIAL -dec at 1-> EMPTY.
  - FULL -dec-> PARTIAL.
  - Any -clear-> EMPTY.
  - full/empty are decoded from the next state and registered, so they track count with no extra lag.
- Blink prescaler:
  - In EMPTY/PARTIAL it counts 0..BLINK_DIV-1.
  - At terminal count it wraps to 0 and toggles blink.
- Blink restart: any change of count (including clear when count!=0) forces prescaler<=0 and blink<=0 on that edge. The new level is shown steady for a full half-period first.
- FULL: blink held 0 and prescaler held 0. The decoder lights all rows regardless.
- Ignored requests: a saturated request (inc at 7, dec at 0 without wrap) is not a count change and does not restart blink.
- Reset mid-operation: all registers return to reset values immediately and asynchronously.

Optional Feature:
- Macro: LEVEL_WRAP_EN.
- Defined:
  - inc at 7 wraps to 0, entering EMPTY.
  - dec at 0 wraps to 7, entering FULL.
  - Both are count changes and restart blink.
- Undefined: saturating behaviour as above.

Decomposition:
- Shared package level_pkg:
  - State encodings ST_EMPTY=2'd0, ST_PARTIAL=2'd1, ST_FULL=2'd2.
  - LEVEL_MAX=3'd7, LEVEL_W=3.
- Sub-module blink_prescaler:
  - Parameter BLINK_DIV.
  - Ports clk, reset, run, restart, blink.
  - run=0 holds the counter and blink at 0; restart zeroes both.
- Level register, edge detect and FSM live in level_sequencer.

Test Plan (BLINK_DIV=4):
- Reset with inc held high, then release reset -> count stays 0, empty=1; a later inc 0->1 gives count=1 one cycle after the rise.
- 7 inc pulses from 0 -> count 1..7, full=1 on the 7th, blink=0 constant in FULL; 8th inc -> count stays 7 (without LEVEL_WRAP_EN).
- count=3, idle 16 cycles -> blink toggles every 4 cycles (0,0,0,0,1,1,1,1,...); inc mid-phase -> count=4, blink=0 and the phase restarts for 4 cycles.
- inc and dec rise in the same cycle at count=5 -> count stays 5, blink phase not restarted.
- count=6, clear high together with an inc rise -> count=0, empty=1, blink=0 next cycle.
- LEVEL_WRAP_EN defined:
  - count=7 + inc -> count=0, empty=1.
  - count=0 + dec -> count=7, full=1.
